instruction_fetch: RTL and testbench

- IF stage of the 5-stage MIPS32 pipeline, directly upstream of decode.
- Decode sign/zero-extends the 16-bit immediate taken from the instruction word this block delivers.
- Holds the PC and a byte-loadable instruction memory, filled by the debug/UART unit before a run.
- Provides the registered IF/ID outputs, with stall, flush/redirect and HALT detection.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/instruction_memory.sv | 65 ++++++
 rtl/instruction_fetch.sv | 116 +++++++++++
 tb/tb_instruction_fetch.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS32 fetch stage: halt/NOP words, next-PC
// source selects and the fetch controller states.
package mips_pkg;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_SRC_SEQ    = 2'b00,
        PC_SRC_BRANCH = 2'b01,
        PC_SRC_JUMP   = 2'b10,
        PC_SRC_JR     = 2'b11
    } pc_src_t;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/instruction_memory.sv
// Byte-loadable instruction memory: packs big-endian bytes into words and
// serves an asynchronous read that returns NOP for anything not yet loaded.
module instruction_memory
    import mips_pkg::*;
#(
    parameter int PC_SIZE   = 32,
    parameter int INST_SIZE = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_wr_en,
    input  logic [7:0]           i_wr_byte,
    input  logic [PC_SIZE-1:0]   i_rd_addr,
    output logic [INST_SIZE-1:0] o_rd_data,
    output logic                 o_mem_full
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [INST_SIZE-1:0] mem [MEM_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [1:0]           byte_cnt;
    logic [INST_SIZE-9:0] packer;
    logic                 wr_accept;
    logic                 word_done;
    logic [AW-1:0]        rd_idx;
    logic                 rd_hit;

    // The pointer's extra MSB doubles as the full flag once MEM_DEPTH words are in.
    assign o_mem_full = wr_ptr[AW];
    assign wr_accept  = i_wr_en && !o_mem_full;
    assign word_done  = wr_accept && (byte_cnt == 2'd3);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr   <= '0;
            byte_cnt <= '0;
            packer   <= '0;
        end else if (i_clear) begin
            wr_ptr   <= '0;
            byte_cnt <= '0;
            packer   <= '0;
        end else if (wr_accept) begin
            packer   <= {packer[INST_SIZE-17:0], i_wr_byte};
            byte_cnt <= byte_cnt + 2'd1;
            if (word_done) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    // Storage is never erased; clearing only rewinds the pointer that masks it.
    always_ff @(posedge i_clk) begin
        if (word_done && !i_clear && !i_reset) begin
            mem[wr_ptr[AW-1:0]] <= {packer, i_wr_byte};
        end
    end

    assign rd_idx    = i_rd_addr[AW+1:2];
    assign rd_hit    = (i_rd_addr[PC_SIZE-1:AW+2] == '0) && ({1'b0, rd_idx} < wr_ptr);
    assign o_rd_data = rd_hit ? mem[rd_idx] : NOP_WORD;

endmodule

// File: rtl/instruction_fetch.sv
// MIPS32 IF stage: PC, fetch controller and the IF/ID register.
// state     | meaning
// ST_LOAD   | memory accepts bytes, PC frozen until the first enable
// ST_RUN    | fetching one word per enabled cycle
// ST_HALTED | HALT delivered; PC frozen, IF/ID emits NOP until clear/reset
module instruction_fetch #(
    parameter int                   PC_SIZE   = 32,
    parameter int                   INST_SIZE = 32,
    parameter int                   MEM_DEPTH = 256,
    parameter logic [INST_SIZE-1:0] HALT_WORD = mips_pkg::HALT_WORD
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic [1:0]           i_next_pc_src,
    input  logic [PC_SIZE-1:0]   i_branch_addr,
    input  logic [PC_SIZE-1:0]   i_jump_addr,
    input  logic [PC_SIZE-1:0]   i_jr_addr,
    input  logic                 i_wr_en,
    input  logic [7:0]           i_wr_byte,
    input  logic                 i_clear,
    output logic [PC_SIZE-1:0]   o_pc,
    output logic [PC_SIZE-1:0]   o_pc_plus4,
    output logic [INST_SIZE-1:0] o_instruction,
    output logic                 o_valid,
    output logic                 o_halt,
    output logic                 o_mem_full
);

    localparam logic [PC_SIZE-1:0] PC_STEP = PC_SIZE'(4);

    mips_pkg::fetch_state_t state;
    logic [PC_SIZE-1:0]     pc;
    logic [PC_SIZE-1:0]     pc_plus4;
    logic [PC_SIZE-1:0]     redirect_pc;
    logic [INST_SIZE-1:0]   fetch_word;
    logic                   load_wr_en;

    assign pc_plus4   = pc + PC_STEP;
    assign load_wr_en = i_wr_en && (state == mips_pkg::ST_LOAD);

    always_comb begin
        redirect_pc = pc_plus4;
        case (i_next_pc_src)
            mips_pkg::PC_SRC_BRANCH: redirect_pc = i_branch_addr;
            mips_pkg::PC_SRC_JUMP:   redirect_pc = i_jump_addr;
            mips_pkg::PC_SRC_JR:     redirect_pc = i_jr_addr;
            default:                 redirect_pc = pc_plus4;
        endcase
    end

    instruction_memory #(
        .PC_SIZE   (PC_SIZE),
        .INST_SIZE (INST_SIZE),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_imem (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (i_clear),
        .i_wr_en    (load_wr_en),
        .i_wr_byte  (i_wr_byte),
        .i_rd_addr  (pc),
        .o_rd_data  (fetch_word),
        .o_mem_full (o_mem_full)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= mips_pkg::ST_LOAD;
            pc            <= '0;
            o_pc          <= '0;
            o_pc_plus4    <= '0;
            o_instruction <= '0;
            o_valid       <= 1'b0;
            o_halt        <= 1'b0;
        end else if (i_clear) begin
            state         <= mips_pkg::ST_LOAD;
            pc            <= '0;
            o_pc          <= '0;
            o_pc_plus4    <= '0;
            o_instruction <= '0;
            o_valid       <= 1'b0;
            o_halt        <= 1'b0;
        end else if (i_enable) begin
            case (state)
                // The first enabled cycle out of LOAD already fetches.
                mips_pkg::ST_LOAD, mips_pkg::ST_RUN: begin
                    state <= mips_pkg::ST_RUN;
                    if (i_flush) begin
                        pc            <= redirect_pc;
                        o_instruction <= mips_pkg::NOP_WORD;
                        o_valid       <= 1'b0;
                    end else if (!i_stall) begin
                        o_pc          <= pc;
                        o_pc_plus4    <= pc_plus4;
                        o_instruction <= fetch_word;
                        o_valid       <= 1'b1;
                        pc            <= pc_plus4;
                        if (fetch_word == HALT_WORD) begin
                            o_halt <= 1'b1;
                            state  <= mips_pkg::ST_HALTED;
                        end
                    end
                end
                mips_pkg::ST_HALTED: begin
                    o_instruction <= mips_pkg::NOP_WORD;
                    o_valid       <= 1'b0;
                end
                default: state <= mips_pkg::ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: vector tables for fetch/stall/flush
// sequences plus hand-written load, clear, reset and memory-full cases.
module tb_instruction_fetch;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic        i_stall;
    logic        i_flush;
    logic [1:0]  i_next_pc_src;
    logic [31:0] i_branch_addr;
    logic [31:0] i_jump_addr;
    logic [31:0] i_jr_addr;
    logic        i_wr_en;
    logic [7:0]  i_wr_byte;
    logic        i_clear;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
    logic [31:0] o_instruction;
    logic        o_valid;
    logic        o_halt;
    logic        o_mem_full;

    int n_cmp  = 0;
    int n_fail = 0;

    instruction_fetch dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_enable      (i_enable),
        .i_stall       (i_stall),
        .i_flush       (i_flush),
        .i_next_pc_src (i_next_pc_src),
        .i_branch_addr (i_branch_addr),
        .i_jump_addr   (i_jump_addr),
        .i_jr_addr     (i_jr_addr),
        .i_wr_en       (i_wr_en),
        .i_wr_byte     (i_wr_byte),
        .i_clear       (i_clear),
        .o_pc          (o_pc),
        .o_pc_plus4    (o_pc_plus4),
        .o_instruction (o_instruction),
        .o_valid       (o_valid),
        .o_halt        (o_halt),
        .o_mem_full    (o_mem_full)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        en;
        logic        stall;
        logic        flush;
        logic [1:0]  src;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        valid;
        logic        halt;
    } vec_t;

    vec_t vec_a[10];
    vec_t vec_b[16];

    function automatic vec_t mk(input logic en, input logic stall, input logic flush,
                                input logic [1:0] src, input logic [31:0] tgt,
                                input logic [31:0] pc, input logic [31:0] pc4,
                                input logic [31:0] inst, input logic valid, input logic halt);
        vec_t v;
        v.en = en; v.stall = stall; v.flush = flush; v.src = src; v.tgt = tgt;
        v.pc = pc; v.pc4 = pc4; v.inst = inst; v.valid = valid; v.halt = halt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_idle();
        i_enable = 0; i_stall = 0; i_flush = 0; i_next_pc_src = 2'b00;
        i_branch_addr = 0; i_jump_addr = 0; i_jr_addr = 0;
        i_wr_en = 0; i_wr_byte = 0; i_clear = 0;
    endtask

    task automatic load_byte(input logic [7:0] b);
        i_wr_en = 1; i_wr_byte = b;
        tick();
        i_wr_en = 0;
    endtask

    task automatic load_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) load_byte(w[k*8 +: 8]);
    endtask

    task automatic load_prog_a();
        load_word(32'h2008_0005);
        load_word(32'h2009_FFFA);
        load_word(32'hFFFF_FFFF);
    endtask

    task automatic do_clear();
        i_clear = 1;
        tick();
        i_clear = 0;
    endtask

    // Unselected target ports carry distinct decoys so a wrong mux select shows up.
    task automatic apply_vec(input vec_t v, input string tag);
        i_enable      = v.en;
        i_stall       = v.stall;
        i_flush       = v.flush;
        i_next_pc_src = v.src;
        i_branch_addr = (v.src == 2'b01) ? v.tgt : 32'hDEAD_0000;
        i_jump_addr   = (v.src == 2'b10) ? v.tgt : 32'hBEEF_0000;
        i_jr_addr     = (v.src == 2'b11) ? v.tgt : 32'hCAFE_0000;
        tick();
        check({tag, ".pc"},    o_pc,          v.pc);
        check({tag, ".pc4"},   o_pc_plus4,    v.pc4);
        check({tag, ".inst"},  o_instruction, v.inst);
        check({tag, ".valid"}, 32'(o_valid),  32'(v.valid));
        check({tag, ".halt"},  32'(o_halt),   32'(v.halt));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1);
    end

    initial begin
        logic [7:0] wb;

        //           en st fl src    tgt            pc             pc4            inst           v  h
        vec_a[0] = mk(1, 0, 0, 2'b00, 32'h0,        32'h0,         32'h4,         32'h2008_0005, 1, 0);
        vec_a[1] = mk(1, 0, 0, 2'b00, 32'h0,        32'h4,         32'h8,         32'h2009_FFFA, 1, 0);
        vec_a[2] = mk(1, 1, 0, 2'b00, 32'h0,        32'h4,         32'h8,         32'h2009_FFFA, 1, 0);
        vec_a[3] = mk(1, 1, 0, 2'b00, 32'h0,        32'h4,         32'h8,         32'h2009_FFFA, 1, 0);
        vec_a[4] = mk(0, 0, 0, 2'b00, 32'h0,        32'h4,         32'h8,         32'h2009_FFFA, 1, 0);
        vec_a[5] = mk(0, 0, 1, 2'b01, 32'h0,        32'h4,         32'h8,         32'h2009_FFFA, 1, 0);
        vec_a[6] = mk(1, 0, 0, 2'b00, 32'h0,        32'h8,         32'hC,         32'hFFFF_FFFF, 1, 1);
        vec_a[7] = mk(1, 0, 0, 2'b00, 32'h0,        32'h8,         32'hC,         32'h0,         0, 1);
        vec_a[8] = mk(1, 0, 1, 2'b01, 32'h0,        32'h8,         32'hC,         32'h0,         0, 1);
        vec_a[9] = mk(1, 0, 0, 2'b00, 32'h0,        32'h8,         32'hC,         32'h0,         0, 1);

        vec_b[0]  = mk(1, 0, 0, 2'b00, 32'h0,         32'h0,         32'h4,         32'h2008_0005, 1, 0);
        vec_b[1]  = mk(1, 0, 0, 2'b00, 32'h0,         32'h4,         32'h8,         32'h2009_FFFA, 1, 0);
        vec_b[2]  = mk(1, 0, 1, 2'b01, 32'h0,         32'h4,         32'h8,         32'h0,         0, 0);
        vec_b[3]  = mk(1, 0, 0, 2'b00, 32'h0,         32'h0,         32'h4,         32'h2008_0005, 1, 0);
        vec_b[4]  = mk(1, 1, 1, 2'b10, 32'h4,         32'h0,         32'h4,         32'h0,         0, 0);
        vec_b[5]  = mk(1, 0, 0, 2'b00, 32'h0,         32'h4,         32'h8,         32'h2009_FFFA, 1, 0);
        vec_b[6]  = mk(1, 0, 1, 2'b11, 32'h1000_0004, 32'h4,         32'h8,         32'h0,         0, 0);
        vec_b[7]  = mk(1, 0, 0, 2'b00, 32'h0,         32'h1000_0004, 32'h1000_0008, 32'h0,         1, 0);
        vec_b[8]  = mk(1, 0, 1, 2'b00, 32'h0,         32'h1000_0004, 32'h1000_0008, 32'h0,         0, 0);
        vec_b[9]  = mk(1, 0, 0, 2'b00, 32'h0,         32'h1000_000C, 32'h1000_0010, 32'h0,         1, 0);
        vec_b[10] = mk(1, 0, 1, 2'b11, 32'hFFFF_FFFC, 32'h1000_000C, 32'h1000_0010, 32'h0,         0, 0);
        vec_b[11] = mk(1, 0, 0, 2'b00, 32'h0,         32'hFFFF_FFFC, 32'h0,         32'h0,         1, 0);
        vec_b[12] = mk(1, 0, 0, 2'b00, 32'h0,         32'h0,         32'h4,         32'h2008_0005, 1, 0);
        vec_b[13] = mk(1, 0, 1, 2'b10, 32'h6,         32'h0,         32'h4,         32'h0,         0, 0);
        vec_b[14] = mk(1, 0, 0, 2'b00, 32'h0,         32'h6,         32'hA,         32'h2009_FFFA, 1, 0);
        vec_b[15] = mk(1, 0, 0, 2'b00, 32'h0,         32'hA,         32'hE,         32'hFFFF_FFFF, 1, 1);

        set_idle();
        i_reset = 1;
        #12;
        check("rst.pc",    o_pc,              32'h0);
        check("rst.pc4",   o_pc_plus4,        32'h0);
        check("rst.inst",  o_instruction,     32'h0);
        check("rst.valid", 32'(o_valid),      32'h0);
        check("rst.halt",  32'(o_halt),       32'h0);
        check("rst.full",  32'(o_mem_full),   32'h0);
        i_reset = 0;
        tick();

        // Program A: two addi words then HALT, with stall, pause and halt behaviour.
        load_prog_a();
        for (int i = 0; i < 10; i++) apply_vec(vec_a[i], $sformatf("a[%0d]", i));
        set_idle();

        do_clear();
        check("clr.pc",    o_pc,            32'h0);
        check("clr.inst",  o_instruction,   32'h0);
        check("clr.valid", 32'(o_valid),    32'h0);
        check("clr.halt",  32'(o_halt),     32'h0);
        check("clr.full",  32'(o_mem_full), 32'h0);
        i_enable = 1;
        tick();
        check("masked.inst",  o_instruction, 32'h0);
        check("masked.valid", 32'(o_valid),  32'h1);
        check("masked.pc4",   o_pc_plus4,    32'h4);
        i_enable = 0;
        do_clear();

        // One full word plus a dangling byte; writes while running are dropped.
        load_word(32'h2008_0005);
        load_byte(8'hAB);
        i_enable = 1;
        tick();
        check("part.w0", o_instruction, 32'h2008_0005);
        i_enable = 0;
        load_word(32'hDEAD_BEEF);
        i_enable = 1;
        tick();
        check("part.pc", o_pc,          32'h4);
        check("part.w1", o_instruction, 32'h0);
        i_enable = 0;
        do_clear();

        // Redirects of every kind, flush over stall, out-of-range PCs, PC wrap.
        load_prog_a();
        for (int i = 0; i < 16; i++) apply_vec(vec_b[i], $sformatf("b[%0d]", i));
        set_idle();
        do_clear();

        // Asynchronous reset between clock edges.
        load_prog_a();
        i_enable = 1;
        tick();
        tick();
        check("arst.pre_pc", o_pc, 32'h4);
        i_enable = 0;
        #3;
        i_reset = 1;
        #1;
        check("arst.pc",    o_pc,          32'h0);
        check("arst.pc4",   o_pc_plus4,    32'h0);
        check("arst.inst",  o_instruction, 32'h0);
        check("arst.valid", 32'(o_valid),  32'h0);
        #2;
        i_reset = 0;
        tick();
        i_enable = 1;
        tick();
        check("arst.after_inst", o_instruction, 32'h0);
        check("arst.after_pc",   o_pc,          32'h0);
        i_enable = 0;
        do_clear();

        // Fill every word, then one surplus byte.
        for (int w = 0; w < 256; w++) begin
            wb = 8'(w);
            load_word({wb, 8'h11, ~wb, 8'h3C});
            if (w == 254) check("fill.not_full", 32'(o_mem_full), 32'h0);
            if (w == 255) check("fill.full",     32'(o_mem_full), 32'h1);
        end
        load_byte(8'h77);
        check("fill.extra_full", 32'(o_mem_full), 32'h1);
        i_enable = 1;
        tick();
        check("fill.w0", o_instruction, 32'h0011_FF3C);
        i_flush = 1; i_next_pc_src = 2'b10; i_jump_addr = 32'h3FC;
        tick();
        check("fill.flush_valid", 32'(o_valid), 32'h0);
        i_flush = 0; i_next_pc_src = 2'b00;
        tick();
        check("fill.w255_pc", o_pc,          32'h3FC);
        check("fill.w255",    o_instruction, 32'hFF11_003C);
        tick();
        check("fill.oor_pc",   o_pc,          32'h400);
        check("fill.oor_inst", o_instruction, 32'h0);
        i_enable = 0;
        do_clear();
        check("fill.clr_full", 32'(o_mem_full), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
